// File: rtl/rf_access_seq_if.sv
// Bundle between the register-file access sequencer, its clients (decode read port and
// write-back port) and the register bank. The sequencer takes the slave view.
interface rf_access_seq_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_rs0;
  logic [ADDR_W-1:0] rd_rs1;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_rsp_data0;
  logic [DATA_W-1:0] rd_rsp_data1;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wbq_count;
  logic              bank_csbar;
  logic              bank_rdwrbar;
  logic [ADDR_W-1:0] bank_sel_src0;
  logic [ADDR_W-1:0] bank_sel_src1;
  logic [ADDR_W-1:0] bank_sel_dst;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_src0;
  logic [DATA_W-1:0] bank_src1;

  modport slave (
    input  rd_req_valid, rd_rs0, rd_rs1, wb_valid, wb_rd, wb_data, bank_src0, bank_src1,
    output rd_req_ready, rd_rsp_valid, rd_rsp_data0, rd_rsp_data1, wb_ready, wbq_count,
           bank_csbar, bank_rdwrbar, bank_sel_src0, bank_sel_src1, bank_sel_dst, bank_wdata
  );

  modport master (
    output rd_req_valid, rd_rs0, rd_rs1, wb_valid, wb_rd, wb_data, bank_src0, bank_src1,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data0, rd_rsp_data1, wb_ready, wbq_count,
           bank_csbar, bank_rdwrbar, bank_sel_src0, bank_sel_src1, bank_sel_dst, bank_wdata
  );
endinterface

// File: rtl/rf_access_seq.sv
// Register-file access sequencer: arbitrates one bank operation per cycle between operand
// reads and queued write-backs, returning both operands one cycle after issue.
// Optional macro RF_BYPASS_EN: forward pending queue data to reads; otherwise reads that
// hit a pending write are interlocked until the queue has drained past them.
module rf_access_seq #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned WBQ_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  rf_access_seq_if.slave bus
);
  localparam int unsigned IdxW = $clog2(WBQ_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  typedef enum logic [1:0] {OpNop, OpRd, OpWr} op_e;
  op_e op;

  logic [ADDR_W-1:0]    q_rd   [WBQ_DEPTH];
  logic [DATA_W-1:0]    q_data [WBQ_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, count;
  logic [IdxW-1:0]      wr_idx, rd_idx;
  logic                 full, empty, enq, hazard, rd_ready, wb_rdy;
  logic [WBQ_DEPTH-1:0] match0, match1;  // bit k = entry of age k (0 = oldest)
  logic                 rsp_valid_q, zero0_q, zero1_q;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) && (wr_idx == rd_idx);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // x0 write-backs are acknowledged but never queued.
  assign enq    = bus.wb_valid && wb_rdy && (bus.wb_rd != '0);

  // Compare both read indices against every live queue entry, oldest first.
  always_comb begin
    match0 = '0;
    match1 = '0;
    for (int k = 0; k < WBQ_DEPTH; k++) begin
      if (PtrW'(k) < count) begin
        match0[k] = (q_rd[rd_idx + IdxW'(k)] == bus.rd_rs0);
        match1[k] = (q_rd[rd_idx + IdxW'(k)] == bus.rd_rs1);
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic              hit0, hit1, byp_hit0_q, byp_hit1_q;
  logic [DATA_W-1:0] fwd0, fwd1, byp_data0_q, byp_data1_q;

  // Younger matches overwrite older ones, leaving the youngest pending value.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    fwd0 = '0;
    fwd1 = '0;
    for (int k = 0; k < WBQ_DEPTH; k++) begin
      if (match0[k]) begin
        hit0 = 1'b1;
        fwd0 = q_data[rd_idx + IdxW'(k)];
      end
      if (match1[k]) begin
        hit1 = 1'b1;
        fwd1 = q_data[rd_idx + IdxW'(k)];
      end
    end
  end

  assign hazard = 1'b0;

  // Capture forwarded operands at issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit0_q  <= 1'b0;
      byp_hit1_q  <= 1'b0;
      byp_data0_q <= '0;
      byp_data1_q <= '0;
    end else if (op == OpRd) begin
      byp_hit0_q  <= hit0;
      byp_hit1_q  <= hit1;
      byp_data0_q <= fwd0;
      byp_data1_q <= fwd1;
    end
  end
`else
  assign hazard = ((bus.rd_rs0 != '0) && (|match0)) || ((bus.rd_rs1 != '0) && (|match1));
`endif

  // Arbitration: full queue forces a write, then reads, then draining, else idle.
  always_comb begin
    op       = OpNop;
    rd_ready = 1'b0;
    wb_rdy   = 1'b0;
    if (!rst) begin
      wb_rdy = !full;
      if (full) begin
        op = OpWr;
      end else begin
        rd_ready = !hazard;
        if (bus.rd_req_valid && !hazard) begin
          op = OpRd;
        end else if (!empty) begin
          op = OpWr;
        end
      end
    end
  end

  assign bus.rd_req_ready = rd_ready;
  assign bus.wb_ready     = wb_rdy;
  assign bus.wbq_count    = ADDR_W'(count);

  // Drive the bank for the selected operation.
  always_comb begin
    bus.bank_csbar    = 1'b1;
    bus.bank_rdwrbar  = 1'b1;
    bus.bank_sel_src0 = '0;
    bus.bank_sel_src1 = '0;
    bus.bank_sel_dst  = '0;
    bus.bank_wdata    = '0;
    unique case (op)
      OpRd: begin
        bus.bank_csbar    = 1'b0;
        bus.bank_sel_src0 = bus.rd_rs0;
        bus.bank_sel_src1 = bus.rd_rs1;
      end
      OpWr: begin
        bus.bank_csbar   = 1'b0;
        bus.bank_rdwrbar = 1'b0;
        bus.bank_sel_dst = q_rd[rd_idx];
        bus.bank_wdata   = q_data[rd_idx];
      end
      default: ;
    endcase
  end

  // Queue pointers and response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      zero0_q     <= 1'b0;
      zero1_q     <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (op == OpWr) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      rsp_valid_q <= (op == OpRd);
      if (op == OpRd) begin
        zero0_q <= (bus.rd_rs0 == '0);
        zero1_q <= (bus.rd_rs1 == '0);
      end
    end
  end

  // Queue storage needs no reset; pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[wr_idx]   <= bus.wb_rd;
      q_data[wr_idx] <= bus.wb_data;
    end
  end

  // A response landing in a reset cycle is suppressed.
  assign bus.rd_rsp_valid = rsp_valid_q && !rst;

  // Select operand source: zero for x0, forwarded data, or the bank.
  always_comb begin
    bus.rd_rsp_data0 = '0;
    bus.rd_rsp_data1 = '0;
    if (rsp_valid_q && !rst) begin
`ifdef RF_BYPASS_EN
      if (!zero0_q) bus.rd_rsp_data0 = byp_hit0_q ? byp_data0_q : bus.bank_src0;
      if (!zero1_q) bus.rd_rsp_data1 = byp_hit1_q ? byp_data1_q : bus.bank_src1;
`else
      if (!zero0_q) bus.rd_rsp_data0 = bus.bank_src0;
      if (!zero1_q) bus.rd_rsp_data1 = bus.bank_src1;
`endif
    end
  end
endmodule
